sha256_axil_master: RTL

//  AXI4-Lite initiator that hashes one 512-bit block on the SHA-256 AXI-Lite peripheral (myip) with no CPU involvement.

---
 rtl/sha256_axil_master.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sha256_axil_master.sv
// rtl/sha256_axil_master.sv - AXI4-Lite initiator driving one SHA-256 block through the myip hash peripheral
//
// Purpose: writes MSG0..MSG15, pulses CTRL.init, polls STATUS.hash_ready, reads DIG0..DIG7
//          and presents the 256-bit result on a parallel interface.
// Ports:
//   m00_axi_aclk / m00_axi_aresetn : clock (rising edge) / asynchronous active-low reset
//   start, block[511:0]            : one-cycle request and message block (sampled in IDLE)
//   busy, done, error              : progress, one-cycle completion pulse, sticky error flag
//   digest[255:0]                  : result, updated only on a successful run
//   m00_axi_aw*/w*/b*/ar*/r*       : AXI4-Lite master channels
// Build option: SHA_MST_RESP_CHECK_EN - abort with error on any non-OKAY bresp/rresp.
module sha256_axil_master #(
  parameter int C_M00_AXI_ADDR_WIDTH = 9,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_BASE_ADDR          = 0,
  parameter int POLL_TIMEOUT         = 1024
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_aresetn,
  input  logic                              start,
  input  logic [511:0]                      block,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [255:0]                      digest,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam int AW  = C_M00_AXI_ADDR_WIDTH;
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_MSG, S_WR_INIT, S_WR_CLR, S_POLL, S_RD_HASH, S_DONE
  } state_t;

  state_t         r_state, w_next_state;
  logic [3:0]     r_idx, w_next_idx;
  logic [PCW-1:0] r_poll_cnt, w_poll_next;
  logic [511:0]   r_block, w_msg_src;
  logic [255:0]   r_shadow, r_digest;
  logic           r_busy, r_done, r_error;
  logic           r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [AW-1:0]  r_awaddr, r_araddr, w_addr;
  logic [31:0]    r_wdata, w_wdata;
  logic [3:0]     r_wstrb;
  logic [7:0]     w_off;
  logic           w_launch, w_set_err, w_resp_err, w_b_hs, w_r_hs, w_wr_accepted, w_is_write;

  assign w_b_hs = r_bready & m00_axi_bvalid;
  assign w_r_hs = r_rready & m00_axi_rvalid;
  // Both halves of the write are accepted on this edge (either earlier or right now).
  assign w_wr_accepted = (r_awvalid | r_wvalid) & (~r_awvalid | m00_axi_awready)
                       & (~r_wvalid | m00_axi_wready);
  assign w_poll_next = r_poll_cnt + PCW'(1);

`ifdef SHA_MST_RESP_CHECK_EN
  assign w_resp_err = (w_b_hs && (m00_axi_bresp != 2'b00)) || (w_r_hs && (m00_axi_rresp != 2'b00));
`else
  logic w_unused_resp;
  assign w_resp_err    = 1'b0;
  assign w_unused_resp = ^{m00_axi_bresp, m00_axi_rresp};
`endif

  // Next state plus a launch flag: the next transaction is issued on the same edge that
  // completes the previous one, so its valid is visible the following cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_launch     = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_next_state = S_WR_MSG; w_next_idx = 4'd0; w_launch = 1'b1;
      end
      S_WR_MSG: if (w_b_hs) begin
        if (w_resp_err) begin w_next_state = S_DONE; w_set_err = 1'b1; end
        else if (r_idx == 4'd15) begin w_next_state = S_WR_INIT; w_launch = 1'b1; end
        else begin w_next_idx = r_idx + 4'd1; w_launch = 1'b1; end
      end
      S_WR_INIT: if (w_b_hs) begin
        if (w_resp_err) begin w_next_state = S_DONE; w_set_err = 1'b1; end
        else begin w_next_state = S_WR_CLR; w_launch = 1'b1; end
      end
      S_WR_CLR: if (w_b_hs) begin
        if (w_resp_err) begin w_next_state = S_DONE; w_set_err = 1'b1; end
        else begin w_next_state = S_POLL; w_launch = 1'b1; end
      end
      S_POLL: if (w_r_hs) begin
        if (w_resp_err) begin w_next_state = S_DONE; w_set_err = 1'b1; end
        else if (m00_axi_rdata[0]) begin w_next_state = S_RD_HASH; w_next_idx = 4'd0; w_launch = 1'b1; end
        else if (w_poll_next == PCW'(POLL_TIMEOUT)) begin w_next_state = S_DONE; w_set_err = 1'b1; end
        else w_launch = 1'b1;
      end
      S_RD_HASH: if (w_r_hs) begin
        if (w_resp_err) begin w_next_state = S_DONE; w_set_err = 1'b1; end
        else if (r_idx == 4'd7) w_next_state = S_DONE;
        else begin w_next_idx = r_idx + 4'd1; w_launch = 1'b1; end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Address and data of the transaction being launched, keyed on the state it belongs to.
  always_comb begin
    w_is_write = (w_next_state == S_WR_MSG) || (w_next_state == S_WR_INIT) || (w_next_state == S_WR_CLR);
    w_msg_src  = (r_state == S_IDLE) ? block : r_block;
    case (w_next_state)
      S_WR_MSG:  w_off = {2'b00, w_next_idx, 2'b00};
      S_RD_HASH: w_off = 8'h40 + {2'b00, w_next_idx, 2'b00};
      S_POLL:    w_off = 8'h64;
      default:   w_off = 8'h60;
    endcase
    w_addr = AW'(C_BASE_ADDR) + AW'(w_off);
    case (w_next_state)
      S_WR_MSG:  w_wdata = w_msg_src[{w_next_idx, 5'b00000} +: 32];
      S_WR_INIT: w_wdata = 32'd1;
      default:   w_wdata = 32'd0;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      r_state <= S_IDLE;   r_idx <= 4'd0;      r_poll_cnt <= '0;
      r_block <= '0;       r_shadow <= '0;     r_digest <= '0;
      r_busy <= 1'b0;      r_done <= 1'b0;     r_error <= 1'b0;
      r_awvalid <= 1'b0;   r_wvalid <= 1'b0;   r_bready <= 1'b0;
      r_arvalid <= 1'b0;   r_rready <= 1'b0;
      r_awaddr <= '0;      r_araddr <= '0;     r_wdata <= '0;   r_wstrb <= 4'h0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
      r_done  <= 1'b0;
      if (r_awvalid && m00_axi_awready) r_awvalid <= 1'b0;
      if (r_wvalid && m00_axi_wready) begin r_wvalid <= 1'b0; r_wstrb <= 4'h0; end
      if (w_wr_accepted) r_bready <= 1'b1;
      if (w_b_hs) r_bready <= 1'b0;
      if (r_arvalid && m00_axi_arready) begin r_arvalid <= 1'b0; r_rready <= 1'b1; end
      if (w_r_hs) r_rready <= 1'b0;
      if (w_launch) begin
        if (w_is_write) begin
          r_awvalid <= 1'b1; r_wvalid <= 1'b1; r_wstrb <= 4'hF;
          r_awaddr  <= w_addr; r_wdata <= w_wdata;
        end else begin
          r_arvalid <= 1'b1; r_araddr <= w_addr;
        end
      end
      if (r_state == S_IDLE && start) begin
        r_block <= block; r_error <= 1'b0; r_busy <= 1'b1; r_poll_cnt <= '0;
      end
      if (r_state == S_POLL && w_r_hs) r_poll_cnt <= w_poll_next;
      if (r_state == S_RD_HASH && w_r_hs) r_shadow[{r_idx[2:0], 5'b00000} +: 32] <= m00_axi_rdata;
      if (w_next_state == S_DONE && r_state != S_DONE) begin
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
        r_error <= w_set_err;
        // Success only leaves RD_HASH on DIG7, which lands in the top word this edge.
        if (!w_set_err) r_digest <= {m00_axi_rdata, r_shadow[223:0]};
      end
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;
  assign digest          = r_digest;
  assign m00_axi_awaddr  = r_awaddr;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_awvalid = r_awvalid;
  assign m00_axi_wdata   = r_wdata;
  assign m00_axi_wstrb   = r_wstrb;
  assign m00_axi_wvalid  = r_wvalid;
  assign m00_axi_bready  = r_bready;
  assign m00_axi_araddr  = r_araddr;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_arvalid = r_arvalid;
  assign m00_axi_rready  = r_rready;

endmodule
